// File: rtl/fir_frame_ctrl.sv
// Frames ADC samples from a small FIFO into FRAME_LEN-sample FIR packets; first ena_i/sop_i 3 cycles after a sample lands in an empty FIFO.
// Transfers gated by the previous cycle's dav_i, full FIFO drops samples (sticky ovf); `FIR_FRAME_ZERO_PAD_EN` enables flush zero-padding.
module fir_frame_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  smp_valid,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic                  flush,
    input  logic                  dav_i,
    output logic                  ena_i,
    output logic                  sop_i,
    output logic                  eop_i,
    output logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  dav_o,
    input  logic                  out_rdy,
    output logic                  ena_o,
    input  logic                  sop_o,
    input  logic                  eop_o,
    output logic                  ovf,
    output logic                  busy,
    output logic [15:0]           frm_in_cnt,
    output logic [15:0]           frm_out_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [AW:0]   FIFO_FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST      = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_PAD, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ena_i_q, sop_i_q, eop_i_q, ena_o_q, ovf_q;
    logic                  ena_i_d, sop_i_d, eop_i_d, ena_o_d, ovf_d;
    logic [DATA_WIDTH-1:0] dat_i_q, dat_i_d;
    logic [15:0]           frm_in_cnt_q, frm_in_cnt_d, frm_out_cnt_q, frm_out_cnt_d;
    logic                  fifo_empty, fifo_full, push, pop;
    logic                  issue_frame, issue_pad, issue, busy_c, flush_ok;
    logic                  sop_o_unused;

    assign sop_o_unused = sop_o;

`ifdef FIR_FRAME_ZERO_PAD_EN
    // A flush only matters once the frame has started.
    assign flush_ok = flush && (cnt_q != '0);
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign flush_ok     = 1'b0;
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL_LVL);
    assign issue      = issue_frame | issue_pad;
    assign pop        = issue_frame;
    assign push       = smp_valid && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Leaving FRAME/PAD waits for the eop_i cycle so busy covers the last transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_FRAME;
            S_FRAME: begin
                if (eop_i_q)       state_d = S_GAP;
                else if (flush_ok) state_d = S_PAD;
            end
            S_PAD:   if (eop_i_q) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_frame = 1'b0;
        issue_pad   = 1'b0;
        busy_c      = 1'b0;
        case (state_q)
            S_FRAME: begin
                busy_c      = 1'b1;
                issue_frame = dav_i && !eop_i_q && !fifo_empty;
            end
            S_PAD: begin
                busy_c    = 1'b1;
                issue_pad = dav_i && !eop_i_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        ovf_d         = ovf_q | (smp_valid && fifo_full && !pop);
        cnt_d         = cnt_q;
        if (issue)             cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        ena_i_d       = issue;
        sop_i_d       = issue && (cnt_q == '0);
        eop_i_d       = issue && (cnt_q == CNT_LAST);
        dat_i_d       = issue_frame ? mem_q[rd_ptr_q] : '0;
        ena_o_d       = dav_o & out_rdy;
        frm_in_cnt_d  = (ena_i_q && eop_i_q) ? frm_in_cnt_q + 16'd1 : frm_in_cnt_q;
        frm_out_cnt_d = (ena_o_q && eop_o) ? frm_out_cnt_q + 16'd1 : frm_out_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= smp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            ena_i_q       <= 1'b0;
            sop_i_q       <= 1'b0;
            eop_i_q       <= 1'b0;
            dat_i_q       <= '0;
            ena_o_q       <= 1'b0;
            frm_in_cnt_q  <= '0;
            frm_out_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            ena_i_q       <= ena_i_d;
            sop_i_q       <= sop_i_d;
            eop_i_q       <= eop_i_d;
            dat_i_q       <= dat_i_d;
            ena_o_q       <= ena_o_d;
            frm_in_cnt_q  <= frm_in_cnt_d;
            frm_out_cnt_q <= frm_out_cnt_d;
        end
    end

    assign ena_i       = ena_i_q;
    assign sop_i       = sop_i_q;
    assign eop_i       = eop_i_q;
    assign dat_i       = dat_i_q;
    assign ena_o       = ena_o_q;
    assign ovf         = ovf_q;
    assign busy        = busy_c;
    assign frm_in_cnt  = frm_in_cnt_q;
    assign frm_out_cnt = frm_out_cnt_q;
endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Bench for fir_frame_ctrl: scoreboard of expected FIR input transfers plus a vector table for the result side.
module tb_fir_frame_ctrl;
    logic        clk = 1'b0;
    logic        rst, smp_valid, flush, dav_i, dav_o, out_rdy, sop_o, eop_o;
    logic [15:0] smp_data;
    logic        ena_i, sop_i, eop_i, ena_o, ovf, busy;
    logic [15:0] dat_i, frm_in_cnt, frm_out_cnt;

    fir_frame_ctrl #(.DATA_WIDTH(16), .FRAME_LEN(16), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .smp_valid(smp_valid), .smp_data(smp_data), .flush(flush),
        .dav_i(dav_i), .ena_i(ena_i), .sop_i(sop_i), .eop_i(eop_i), .dat_i(dat_i),
        .dav_o(dav_o), .out_rdy(out_rdy), .ena_o(ena_o), .sop_o(sop_o), .eop_o(eop_o),
        .ovf(ovf), .busy(busy), .frm_in_cnt(frm_in_cnt), .frm_out_cnt(frm_out_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dat;
        logic        sop;
        logic        eop;
    } exp_t;

    typedef struct {
        logic        dav_o, out_rdy, eop_o, sop_o;
        logic        exp_ena_o;
        logic [15:0] exp_cnt;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;
    int   pos    = 0;
    logic prev_dav = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic push_exp(input int v);
        exp_t e;
        e.dat = v[15:0];
        e.sop = (pos == 0);
        e.eop = (pos == 15);
        exp_q.push_back(e);
        pos = (pos + 1) % 16;
    endtask

    task automatic send(input int v, input bit expect_it);
        smp_valid = 1'b1;
        smp_data  = v[15:0];
        if (expect_it) push_exp(v);
        @(posedge clk); #1;
        smp_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
        end
    endtask

    always @(posedge clk) prev_dav <= dav_i;

    always @(negedge clk) begin
        if (ena_i) begin
            exp_t e;
            xfers++;
            if (!prev_dav) chk("xfer_after_dav0", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer_dat", {16'd0, dat_i}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_dat", {16'd0, dat_i}, {16'd0, e.dat});
                chk("xfer_sop", {31'd0, sop_i}, {31'd0, e.sop});
                chk("xfer_eop", {31'd0, eop_i}, {31'd0, e.eop});
            end
        end else if (sop_i || eop_i) begin
            chk("sop_eop_without_ena", {30'd0, sop_i, eop_i}, 32'd0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   first, base, n;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};

        rst = 1'b1; smp_valid = 1'b0; smp_data = '0; flush = 1'b0;
        dav_i = 1'b0; dav_o = 1'b0; out_rdy = 1'b0; sop_o = 1'b0; eop_o = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ena_i", {31'd0, ena_i}, 32'd0);
        chk("rst_sop_eop", {30'd0, sop_i, eop_i}, 32'd0);
        chk("rst_dat_i", {16'd0, dat_i}, 32'd0);
        chk("rst_ena_o", {31'd0, ena_o}, 32'd0);
        chk("rst_ovf_busy", {30'd0, ovf, busy}, 32'd0);
        chk("rst_frm_in_cnt", {16'd0, frm_in_cnt}, 32'd0);
        chk("rst_frm_out_cnt", {16'd0, frm_out_cnt}, 32'd0);
        rst = 1'b0;

        // Basic 16-sample frame with latency measurement
        dav_i = 1'b1; out_rdy = 1'b1; first = -1; base = xfers;
        for (int i = 0; i < 16; i++) begin
            smp_valid = 1'b1;
            smp_data  = 16'(i + 1);
            push_exp(i + 1);
            @(posedge clk); #1;
            if (ena_i && first < 0) first = i + 1;
        end
        smp_valid = 1'b0;
        chk("first_xfer_latency", first, 3);
        wait_drain(200);
        repeat (3) @(posedge clk);
        #1;
        chk("basic_xfers", xfers - base, 16);
        chk("basic_frm_in_cnt", {16'd0, frm_in_cnt}, 32'd1);
        chk("basic_busy_after_gap", {31'd0, busy}, 32'd0);

        // dav_i toggling every cycle
        base = xfers;
        fork
            begin
                for (int i = 0; i < 16; i++) send(17 + i, 1'b1);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    dav_i = (k % 2 == 0);
                    @(posedge clk); #1;
                end
            end
        join
        dav_i = 1'b1;
        wait_drain(200);
        repeat (3) @(posedge clk);
        #1;
        chk("toggle_xfers", xfers - base, 16);
        chk("toggle_frm_in_cnt", {16'd0, frm_in_cnt}, 32'd2);

        // Partial frame plus flush
        base = xfers;
        for (int i = 0; i < 5; i++) send(i + 1, 1'b1);
        wait_drain(100);
        repeat (2) @(posedge clk);
        #1;
`ifdef FIR_FRAME_ZERO_PAD_EN
        for (int i = 0; i < 11; i++) push_exp(0);
`endif
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
`ifdef FIR_FRAME_ZERO_PAD_EN
        wait_drain(100);
        repeat (3) @(posedge clk);
        #1;
        chk("pad_xfers", xfers - base, 16);
        chk("pad_busy_after", {31'd0, busy}, 32'd0);
`else
        repeat (20) @(posedge clk);
        #1;
        chk("nopad_xfers", xfers - base, 5);
        chk("nopad_busy_held", {31'd0, busy}, 32'd1);
        for (int i = 5; i < 16; i++) send(i + 1, 1'b1);
        wait_drain(100);
        repeat (3) @(posedge clk);
        #1;
`endif
        chk("flush_frm_in_cnt", {16'd0, frm_in_cnt}, 32'd3);

        // Overflow: 20 samples with the sink stalled
        dav_i = 1'b0; base = xfers;
        chk("ovf_before", {31'd0, ovf}, 32'd0);
        for (int v = 1; v <= 20; v++) send(v, v <= 16);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        chk("ovf_no_xfer_stalled", xfers - base, 0);
        dav_i = 1'b1;
        wait_drain(200);
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_xfers", xfers - base, 16);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        chk("ovf_frm_in_cnt", {16'd0, frm_in_cnt}, 32'd4);

        // Reset after the 7th transfer of a frame
        dav_i = 1'b0;
        for (int i = 0; i < 16; i++) send(201 + i, 1'b1);
        dav_i = 1'b1; n = 0;
        for (int c = 0; c < 100 && n < 7; c++) begin
            @(posedge clk); #1;
            if (ena_i) n++;
        end
        chk("midrst_reach_7", n, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        pos = 0;
        chk("midrst_ena_i", {31'd0, ena_i}, 32'd0);
        chk("midrst_sop_eop", {30'd0, sop_i, eop_i}, 32'd0);
        chk("midrst_dat_i", {16'd0, dat_i}, 32'd0);
        chk("midrst_ovf_busy_ena_o", {29'd0, ovf, busy, ena_o}, 32'd0);
        chk("midrst_frm_in_cnt", {16'd0, frm_in_cnt}, 32'd0);
        chk("midrst_frm_out_cnt", {16'd0, frm_out_cnt}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_fifo_discarded_busy", {31'd0, busy}, 32'd0);
        base = xfers;
        for (int i = 0; i < 16; i++) send(301 + i, 1'b1);
        wait_drain(200);
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_xfers", xfers - base, 16);
        chk("postrst_frm_in_cnt", {16'd0, frm_in_cnt}, 32'd1);

        // Result side vector table
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ena_o", i), {31'd0, ena_o}, {31'd0, vecs[i].exp_ena_o});
            chk($sformatf("vec%0d_frm_out_cnt", i), {16'd0, frm_out_cnt}, {16'd0, vecs[i].exp_cnt});
            dav_o   = vecs[i].dav_o;
            out_rdy = vecs[i].out_rdy;
            eop_o   = vecs[i].eop_o;
            sop_o   = vecs[i].sop_o;
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
